// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the DSP MAC sequencer.
// Contents:
//   OPM_MULT / OPM_MACC  OPMODE words driven to the slice
//   state_e              vector-tracking FSM state
//   tag_t                per-beat tag carried alongside the slice pipeline
package dsp_mac_pkg;

  // Z=0, X=M : start a new accumulation from the current product.
  localparam logic [7:0] OPM_MULT = 8'h01;
  // Z=P, X=M : add the current product to the running P.
  localparam logic [7:0] OPM_MACC = 8'h09;

  typedef enum logic {
    IDLE,
    ACC
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

endpackage

// File: rtl/dsp_tag_pipe.sv
// CE-gated shift register used to track side-band information through the
// slice register stages.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_ce       advance all stages when high, hold otherwise
//   i_data     value entering stage 0
//   o_data     value leaving the last stage (i_data itself when DEPTH = 0)
module dsp_tag_pipe #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_bypass
    assign o_data = i_data;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
      end else if (i_ce) begin
        r_stage[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_data = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streaming front-end and result collector for a DSP48A1-style slice used as
// a multiply-accumulator. Operand pairs are issued straight to the slice; a
// tag line follows each beat through the slice registers so P can be captured
// when the last element of a vector emerges.
// Optional build macro: DSP_MAC_CNT_EN adds a per-vector element counter
// reported on m_count (tied to 0 otherwise).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   s_valid/s_ready/s_a/s_b/s_last operand input stream
//   dsp_a/dsp_b/dsp_ce/dsp_opmode slice controls, dsp_p slice result
//   m_valid/m_ready/m_data/m_count result stream
module dsp_mac_sequencer
  import dsp_mac_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned OPM_DLY  = 2,
  parameter int unsigned A_W      = 18,
  parameter int unsigned B_W      = 18,
  parameter int unsigned P_W      = 48,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [A_W-1:0]   s_a,
  input  logic [B_W-1:0]   s_b,
  input  logic             s_last,
  output logic [A_W-1:0]   dsp_a,
  output logic [B_W-1:0]   dsp_b,
  output logic             dsp_ce,
  output logic [7:0]       dsp_opmode,
  input  logic [P_W-1:0]   dsp_p,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [P_W-1:0]   m_data,
  output logic [CNT_W-1:0] m_count
);

  state_e           r_state, w_state_next;
  logic             w_ce, w_issue, w_first, w_opm_first, w_capture;
  tag_t             w_tag_in, w_tag_out;
  logic [TAG_W-1:0] w_tag_out_raw;
  logic             w_unused_first;
  logic             r_m_valid;
  logic [P_W-1:0]   r_m_data;

  // A pending result that is not taken freezes the whole slice pipeline.
  assign w_ce    = ~(r_m_valid & ~m_ready);
  assign s_ready = w_ce;
  assign dsp_ce  = w_ce;
  assign w_issue = s_valid & w_ce;

  // Bubbles present zero operands so M=0 and accumulation is undisturbed.
  assign dsp_a = w_issue ? s_a : '0;
  assign dsp_b = w_issue ? s_b : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_first      = (r_state == IDLE);
    if (w_issue) w_state_next = s_last ? IDLE : ACC;
  end

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_issue;
    w_tag_in.first = w_issue & w_first;
    w_tag_in.last  = w_issue & s_last;
  end

  dsp_tag_pipe #(
    .DEPTH   (PIPE_LAT),
    .WIDTH   (TAG_W),
    .RST_VAL ('0)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_ce   (w_ce),
    .i_data (w_tag_in),
    .o_data (w_tag_out_raw)
  );

  assign w_tag_out      = tag_t'(w_tag_out_raw);
  // The first bit rides along for visibility in waves; capture only needs last.
  assign w_unused_first = w_tag_out.first;

  // Reset value 1 holds OPMODE at MULT out of reset; the slice is cleared then,
  // so restarting from M=0 is equivalent to holding P.
  dsp_tag_pipe #(
    .DEPTH   (OPM_DLY),
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_opm_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_ce   (w_ce),
    .i_data (w_tag_in.first),
    .o_data (w_opm_first)
  );

  assign dsp_opmode = w_opm_first ? OPM_MULT : OPM_MACC;

  assign w_capture = w_ce & w_tag_out.valid & w_tag_out.last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (w_capture) begin
      r_m_valid <= 1'b1;
      r_m_data  <= dsp_p;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;

`ifdef DSP_MAC_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_out, r_m_count;

  // Count of elements up to and including the beat being issued.
  assign w_cnt_next = w_first ? CNT_W'(1) : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= '0;
    else if (w_issue) r_cnt <= w_cnt_next;
  end

  dsp_tag_pipe #(
    .DEPTH   (PIPE_LAT),
    .WIDTH   (CNT_W),
    .RST_VAL ('0)
  ) u_cnt_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_ce   (w_ce),
    .i_data (w_cnt_next),
    .o_data (w_cnt_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_m_count <= '0;
    else if (w_capture) r_m_count <= w_cnt_out;
  end

  assign m_count = r_m_count;
`else
  assign m_count = '0;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer. A simple DSP slice model
// (A/B reg, M reg, P reg with Z=P/0 selected by OPMODE) closes the loop; the
// expected results come from summing operand products per vector.
module tb_dsp_mac_sequencer;

  localparam int unsigned PIPE_LAT = 3;
  localparam int unsigned OPM_DLY  = 2;
  localparam int unsigned A_W      = 18;
  localparam int unsigned B_W      = 18;
  localparam int unsigned P_W      = 48;
  localparam int unsigned CNT_W    = 16;
  localparam logic [7:0]  OPM_MULT = 8'h01;
  localparam logic [7:0]  OPM_MACC = 8'h09;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid, s_ready, s_last;
  logic [A_W-1:0]   s_a, dsp_a;
  logic [B_W-1:0]   s_b, dsp_b;
  logic             dsp_ce;
  logic [7:0]       dsp_opmode;
  logic [P_W-1:0]   dsp_p;
  logic             m_valid, m_ready;
  logic [P_W-1:0]   m_data;
  logic [CNT_W-1:0] m_count;

  int total = 0;
  int bad   = 0;
  bit rnd   = 0;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(
    .PIPE_LAT (PIPE_LAT),
    .OPM_DLY  (OPM_DLY),
    .A_W      (A_W),
    .B_W      (B_W),
    .P_W      (P_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_a        (s_a),
    .s_b        (s_b),
    .s_last     (s_last),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_ce     (dsp_ce),
    .dsp_opmode (dsp_opmode),
    .dsp_p      (dsp_p),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_count    (m_count)
  );

  // Slice model sharing rst with the sequencer.
  logic signed [A_W-1:0] sl_a;
  logic signed [B_W-1:0] sl_b;
  logic signed [P_W-1:0] sl_m, sl_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sl_a <= '0;
      sl_b <= '0;
      sl_m <= '0;
      sl_p <= '0;
    end else if (dsp_ce) begin
      sl_a <= dsp_a;
      sl_b <= dsp_b;
      sl_m <= P_W'(sl_a) * P_W'(sl_b);
      sl_p <= ((dsp_opmode[3:2] == 2'b10) ? sl_p : '0) + sl_m;
    end
  end

  assign dsp_p = sl_p;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference model: running sum of products per vector, queued on last.
  longint            acc = 0;
  int                cnt = 0;
  bit                in_vec = 0;
  logic [P_W-1:0]    exp_data_q [$];
  logic [CNT_W-1:0]  exp_cnt_q  [$];

  always @(negedge clk) begin
    if (rst) begin
      acc = 0;
      cnt = 0;
      in_vec = 0;
      exp_data_q.delete();
      exp_cnt_q.delete();
    end else begin
      // Result side first: a result handed over now was queued earlier.
      if (m_valid && m_ready) begin
        if (exp_data_q.size() == 0) begin
          chk("unexpected_result", 64'(m_data), 64'hdead);
        end else begin
          logic [P_W-1:0]   ed;
          logic [CNT_W-1:0] ec;
          ed = exp_data_q.pop_front();
          ec = exp_cnt_q.pop_front();
          chk("m_data", 64'(m_data), 64'(ed));
`ifdef DSP_MAC_CNT_EN
          chk("m_count", 64'(m_count), 64'(ec));
`else
          chk("m_count", 64'(m_count), 64'(0) & 64'(ec));
`endif
        end
      end
      if (s_valid && s_ready) begin
        if (!in_vec) begin
          acc = 0;
          cnt = 0;
        end
        acc += longint'(signed'(s_a)) * longint'(signed'(s_b));
        if (cnt < (1 << CNT_W) - 1) cnt++;
        in_vec = !s_last;
        if (s_last) begin
          exp_data_q.push_back(acc[P_W-1:0]);
          exp_cnt_q.push_back(CNT_W'(cnt));
        end
      end
    end
  end

  task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic last);
    bit ok = 0;
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    s_last  = last;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      if (!ok && rnd) m_ready = 1'($urandom_range(0, 1));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!ok) chk("issue_timeout", 64'(ok), 64'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd) m_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain(input string tag);
    bit done = 0;
    m_ready = 1'b1;
    rnd     = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      done = (exp_data_q.size() == 0) && !m_valid;
    end
    chk(tag, 64'(exp_data_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Waits for m_valid after the last issue; checks OPMODE at the aligned cycle.
  task automatic watch(input string tag, input logic [7:0] opm_want);
    int lat = 0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(negedge clk);
      if (n == OPM_DLY) chk({tag, "_opmode"}, 64'(dsp_opmode), 64'(opm_want));
      if (m_valid) lat = n;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(PIPE_LAT + 1));
    @(negedge clk);
    chk({tag, "_pulse_end"}, 64'(m_valid), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_a     = '0;
    s_b     = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_m_count", 64'(m_count), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    chk("rst_dsp_ce", 64'(dsp_ce), 64'(1));
    chk("rst_opmode", 64'(dsp_opmode), 64'(OPM_MULT));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Single vector: 3*4 + 5*6 + (-2)*7 = 28; aligned OPMODE is MACC
    send(18'sd3, 18'sd4, 1'b0);
    send(18'sd5, 18'sd6, 1'b0);
    send(-18'sd2, 18'sd7, 1'b1);
    watch("vec3", OPM_MACC);
    drain("drain_vec3");

    // Single-element vector: -300, aligned OPMODE is MULT
    send(18'sd100, -18'sd3, 1'b1);
    watch("single", OPM_MULT);
    drain("drain_single");

    // Back-to-back vectors: 5 then 100
    send(18'sd1, 18'sd1, 1'b0);
    send(18'sd2, 18'sd2, 1'b1);
    send(18'sd10, 18'sd10, 1'b1);
    drain("drain_b2b");

    // Backpressure: result 5 held for 5 cycles, nothing accepted
    m_ready = 1'b0;
    send(18'sd1, 18'sd1, 1'b0);
    send(18'sd2, 18'sd2, 1'b1);
    begin
      int w = 0;
      for (int n = 0; n < 20 && w == 0; n++) begin
        @(negedge clk);
        if (m_valid) w = 1;
      end
      chk("stall_result_seen", 64'(w), 64'(1));
    end
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_a     = 18'sd3;
    s_b     = 18'sd3;
    s_last  = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_s_ready", 64'(s_ready), 64'(0));
      chk("stall_dsp_ce", 64'(dsp_ce), 64'(0));
      chk("stall_m_data", 64'(m_data), 64'(5));
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    send(18'sd3, 18'sd3, 1'b1);
    drain("drain_stall");

    // Bubbles inside a 4-element vector of (2,3): 24
    send(18'sd2, 18'sd3, 1'b0);
    @(negedge clk);
    chk("bubble_dsp_a", 64'(dsp_a), 64'(0));
    chk("bubble_dsp_b", 64'(dsp_b), 64'(0));
    idle(2);
    send(18'sd2, 18'sd3, 1'b0);
    idle(1);
    send(18'sd2, 18'sd3, 1'b0);
    idle(3);
    send(18'sd2, 18'sd3, 1'b1);
    drain("drain_bubble");

    // Reset mid-vector discards the partial sum: next result 49
    send(18'sd5, 18'sd5, 1'b0);
    send(18'sd6, 18'sd6, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_m_valid", 64'(m_valid), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    send(18'sd7, 18'sd7, 1'b1);
    watch("after_rst", OPM_MULT);
    drain("drain_midrst");

    // Randomized vectors with gaps and random backpressure
    rnd = 1;
    for (int v = 0; v < 25; v++) begin
      int len = $urandom_range(1, 5);
      for (int e = 0; e < len; e++) begin
        logic [A_W-1:0] ra;
        logic [B_W-1:0] rb;
        ra = A_W'($urandom);
        rb = B_W'($urandom);
        send(ra, rb, e == len - 1);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
    end
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
